// File: rtl/data_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_port_arbiter_if
//
// Bundle of every bus signal around the data-port arbiter: the two requester
// ports (m0 = CPU core data port, m1 = boot loader / DMA) and the single
// downstream port into the address decoder / RAM / UART register file.
//
// Modports:
//   master - the environment side: drives requests and s_rdata, observes
//            grants, read returns and the downstream drive.
//   slave  - the arbiter side: consumes requests and s_rdata, drives grants,
//            read returns and the downstream port.
//
// Signal summary:
//   mX_req      transfer request, held until granted
//   mX_addr     30-bit word address
//   mX_wdata    32-bit write data
//   mX_wr       1 = write, 0 = read
//   mX_byte_en  byte lanes
//   mX_lock     ask to keep the grant next cycle
//   mX_gnt      transfer issued this cycle (combinational)
//   mX_rvalid   read data valid for this requester
//   mX_rdata    read data (always s_rdata, qualify with mX_rvalid)
//   s_*         downstream port drive, all zero when nothing issues
//   s_rdata     read data coming back from the downstream mux
// ---------------------------------------------------------------------------
interface data_port_arbiter_if;

    // Requester 0
    logic        m0_req;
    logic [29:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_wr;
    logic [3:0]  m0_byte_en;
    logic        m0_lock;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    // Requester 1
    logic        m1_req;
    logic [29:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_wr;
    logic [3:0]  m1_byte_en;
    logic        m1_lock;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    // Downstream port
    logic [29:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;
    logic [3:0]  s_byte_en;
    logic        s_addr_strobe;
    logic [31:0] s_rdata;

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wr, m0_byte_en, m0_lock,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr, m1_wdata, m1_wr, m1_byte_en, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_addr, s_wdata, s_wr, s_byte_en, s_addr_strobe,
        output s_rdata
    );

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wr, m0_byte_en, m0_lock,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr, m1_wdata, m1_wr, m1_byte_en, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_addr, s_wdata, s_wr, s_byte_en, s_addr_strobe,
        input  s_rdata
    );

endinterface

// File: rtl/data_port_arbiter.sv
// ---------------------------------------------------------------------------
// data_port_arbiter
//
// Two-requester arbiter for the single data-side memory/IO port.
//   - Per-cycle round-robin grant between m0 and m1.
//   - A requester may hold the grant with mX_lock for back-to-back transfers,
//     bounded to MAX_BURST consecutive grants while the other one waits.
//   - Read data is routed back to the issuing requester READ_LATENCY cycles
//     after issue through an owner-tagged shift pipe; the pipe never stalls.
//
// Parameters:
//   READ_LATENCY  cycles from read issue to valid s_rdata (1..4)
//   MAX_BURST     max consecutive locked grants under contention (2..255)
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    data_port_arbiter_if.slave (requester ports and downstream port)
// ---------------------------------------------------------------------------
module data_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_port_arbiter_if.slave   bus
);

    localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                    last_owner_q, last_owner_d;
    logic                    lock_prev_q, lock_prev_d;   // owner issued last cycle with lock=1
    logic [7:0]              burst_cnt_q, burst_cnt_d;
    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [READ_LATENCY-1:0] pipe_owner_q;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic owner_req;
    logic locked;
    logic gnt0, gnt1;
    logic issue;

    always_comb begin
        owner_req = last_owner_q ? bus.m1_req : bus.m0_req;
        locked    = lock_prev_q && owner_req && (burst_cnt_q < MaxBurst);

        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            // Contention: the locked owner keeps the port, otherwise alternate.
            if (locked) begin
                gnt1 = last_owner_q;
            end else begin
                gnt1 = ~last_owner_q;
            end
            gnt0 = ~gnt1;
        end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
        end
        issue = gnt0 | gnt1;
    end

    // -----------------------------------------------------------------------
    // Granted-requester mux. Only the granted side is ever selected, so the
    // ungranted requester's inputs cannot leak into anything.
    // -----------------------------------------------------------------------
    logic [29:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_wr;
    logic [3:0]  sel_byte_en;
    logic        sel_lock;
    logic        other_req;

    always_comb begin
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_wr      = 1'b0;
        sel_byte_en = '0;
        sel_lock    = 1'b0;
        other_req   = 1'b0;
        if (gnt0) begin
            sel_addr    = bus.m0_addr;
            sel_wdata   = bus.m0_wdata;
            sel_wr      = bus.m0_wr;
            sel_byte_en = bus.m0_byte_en;
            sel_lock    = bus.m0_lock;
            other_req   = bus.m1_req;
        end else if (gnt1) begin
            sel_addr    = bus.m1_addr;
            sel_wdata   = bus.m1_wdata;
            sel_wr      = bus.m1_wr;
            sel_byte_en = bus.m1_byte_en;
            sel_lock    = bus.m1_lock;
            other_req   = bus.m0_req;
        end
    end

    // -----------------------------------------------------------------------
    // Owner / burst bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        last_owner_d = issue ? gnt1 : last_owner_q;
        lock_prev_d  = issue && sel_lock;

        if (!issue || !sel_lock) begin
            burst_cnt_d = '0;
        end else if (gnt1 != last_owner_q) begin
            // New owner: the count restarts, and this grant is the first of
            // its burst when the other side is already waiting.
            burst_cnt_d = other_req ? 8'd1 : 8'd0;
        end else if (other_req && (burst_cnt_q < MaxBurst)) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
            // Saturated (or uncontended): hold. At MaxBurst the lock no longer
            // wins, so the waiting requester takes the very next grant.
            burst_cnt_d = burst_cnt_q;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b1;   // m0 wins the first contention
            lock_prev_q  <= 1'b0;
            burst_cnt_q  <= '0;
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
        end else begin
            last_owner_q    <= last_owner_d;
            lock_prev_q     <= lock_prev_d;
            burst_cnt_q     <= burst_cnt_d;
            // Writes push an empty slot so later reads keep their timing.
            pipe_valid_q[0] <= issue && !sel_wr;
            pipe_owner_q[0] <= gnt1;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_owner_q[i] <= pipe_owner_q[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.m0_gnt        = gnt0;
        bus.m1_gnt        = gnt1;

        bus.s_addr        = sel_addr;
        bus.s_wdata       = sel_wdata;
        bus.s_wr          = sel_wr;
        bus.s_byte_en     = sel_byte_en;
        bus.s_addr_strobe = issue;

        bus.m0_rvalid     = pipe_valid_q[READ_LATENCY-1] && !pipe_owner_q[READ_LATENCY-1];
        bus.m1_rvalid     = pipe_valid_q[READ_LATENCY-1] &&  pipe_owner_q[READ_LATENCY-1];
        bus.m0_rdata      = bus.s_rdata;
        bus.m1_rdata      = bus.s_rdata;
    end

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
Two-requester arbiter for the single data-side memory/IO port that feeds the address decoder, dual-port RAM data port and UART register file. Requester 0 is the CPU core data port; requester 1 is a secondary master (UART boot loader / DMA engine).
- Per-cycle round-robin grant, optional bounded lock for back-to-back transfers.
- Routes read data back to the issuing requester after a fixed read latency.

Parameters:
- READ_LATENCY, 1, cycles from read issue to valid s_rdata (1..4).
- MAX_BURST, 8, max consecutive locked grants to one requester while the other is waiting (2..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- m0_req, m1_req  input  1 each  transfer request, held until granted
- m0_addr, m1_addr  input  30 each  word address
- m0_wdata, m1_wdata  input  32 each  write data
- m0_wr, m1_wr  input  1 each  1=write, 0=read
- m0_byte_en, m1_byte_en  input  4 each  byte lanes
- m0_lock, m1_lock  input  1 each  request to keep the grant next cycle
- m0_gnt, m1_gnt  output  1 each  transfer issued this cycle (combinational)
- m0_rvalid, m1_rvalid  output  1 each  read data valid for this requester
- m0_rdata, m1_rdata  output  32 each  read data
- s_addr  output  30  to port
- s_wdata  output  32  to port
- s_wr  output  1  to port
- s_byte_en  output  4  to port
- s_addr_strobe  output  1  to port
- s_rdata  input  32  from port (RAM/UART mux)

Behaviour:
- Issue occurs when mX_req && mX_gnt; at most one gnt per cycle.
- Arbitration (combinational from req, last_owner, lock state):
  - Only one requester active: that requester is granted.
  - Both active: granted to the requester ≠ last_owner, unless the locked condition holds.
  - Locked condition: last_owner issued in the previous cycle with its lock=1, still requests, and burst_cnt < MAX_BURST. In that case last_owner keeps the grant.
- last_owner register:
  - Updated to the granted requester on every issue; held otherwise.
  - Reset value 1, so m0 wins the first contention.
- burst_cnt (8-bit):
  - Increments on each issue by last_owner while the other requester is requesting.
  - Cleared on owner change, on any cycle without issue, or when the issuing lock=0.
  - Saturates at MAX_BURST.
  - When MAX_BURST is reached, the other requester gets exactly one grant, then normal arbitration resumes.
- Slave drive:
  - s_addr, s_wdata, s_wr and s_byte_en mirror the granted requester.
  - s_addr_strobe=1 on issue.
  - No issue: all s_* are 0.
- Read return:
  - Read issue (wr=0) pushes {valid=1, owner} into a READ_LATENCY-deep shift pipe.
  - At the pipe output, mOwner_rvalid=1 for one cycle.
  - Both mX_rdata = s_rdata unconditionally; consumers qualify with rvalid.
  - Writes push valid=0.
  - Pipe shifts every cycle, so back-to-back reads, including reads interleaved between masters, return in issue order, one per cycle.
- Simultaneous read return and new issue are independent; no stall.
- Reset values: all gnt=0 (comb, req=0 after reset), rvalid=0, pipe cleared, burst_cnt=0, last_owner=1, s_* = 0.
- Reset mid-operation (async): in-flight reads are discarded and no rvalid is produced. Requesters must re-issue.
- X-safety: outputs depend only on the granted requester's inputs; ungranted inputs are don't-care.

Test Plan:
- Reset, then m0_req=1 read addr 0x10, READ_LATENCY=1, s_rdata=0xDEADBEEF -> m0_gnt same cycle, s_addr=0x10, s_addr_strobe=1; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Both req continuously, lock=0 -> grants alternate m0,m1,m0,m1 starting with m0; s_addr alternates accordingly.
- m1 lock=1 with both requesting, MAX_BURST=4 -> m1 granted 4 consecutive cycles, m0 granted once, then m1 again.
- m0 read, m1 read, m0 write in consecutive cycles, READ_LATENCY=2 -> m0_rvalid at cycle 2, m1_rvalid at cycle 3; no rvalid for the write; s_wr=1 only in cycle 2.
- rst_n pulled low one cycle after a read issue with READ_LATENCY=3 -> no rvalid ever asserted for that read; last_owner=1, next contention granted to m0.
- No requests for 10 cycles -> s_addr_strobe=0, s_wr=0, s_addr=0, burst_cnt returns to 0; a subsequent single m1 request is granted immediately.
